// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle for alu_arbiter.
// slave = arbiter side, master = requesters/ALU side.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [4*NUM_REQ-1:0]      req_fun_i;
    logic [NUM_REQ-1:0]        req_sel_i;
    logic [DATA_W*NUM_REQ-1:0] req_a_i;
    logic [DATA_W*NUM_REQ-1:0] req_b_i;
    logic [DATA_W*NUM_REQ-1:0] req_imm_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ-1:0]        rsp_ready_i;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      rsp_err_o;
    logic                      alu_sel_o;
    logic [3:0]                alu_fun_o;
    logic [DATA_W-1:0]         alu_reg_a_o;
    logic [DATA_W-1:0]         alu_reg_b_o;
    logic [DATA_W-1:0]         alu_imm_ext_o;
    logic [DATA_W-1:0]         alu_out_i;

    modport slave (
        input  req_valid_i, req_fun_i, req_sel_i,
        input  req_a_i, req_b_i, req_imm_i,
        input  rsp_ready_i, alu_out_i,
        output req_ready_o, rsp_valid_o,
        output rsp_data_o, rsp_err_o,
        output alu_sel_o, alu_fun_o,
        output alu_reg_a_o, alu_reg_b_o, alu_imm_ext_o
    );

    modport master (
        output req_valid_i, req_fun_i, req_sel_i,
        output req_a_i, req_b_i, req_imm_i,
        output rsp_ready_i, alu_out_i,
        input  req_ready_o, rsp_valid_o,
        input  rsp_data_o, rsp_err_o,
        input  alu_sel_o, alu_fun_o,
        input  alu_reg_a_o, alu_reg_b_o, alu_imm_ext_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU: IDLE -> EXEC -> RESP per operation.
// Optional ALU_ARB_FUNCHK_EN flags function codes above 4'b0100 as illegal.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [3:0]        fun_q, fun_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [IW-1:0]     grant;
    logic              gnt_vld;
    logic              accept;
`ifdef ALU_ARB_FUNCHK_EN
    logic              bad_q, bad_d;
`endif

    // Search starts just after the last winner and wraps.
    always_comb begin : arb
        logic [IW-1:0] idx;
        idx     = '0;
        grant   = last_q;
        gnt_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (!gnt_vld && bus.req_valid_i[idx]) begin
                grant   = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign accept = rst_ni && (state_q == IDLE) && gnt_vld;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        fun_d   = fun_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef ALU_ARB_FUNCHK_EN
        bad_d   = bad_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    last_d  = grant;
                    owner_d = grant;
                    fun_d   = bus.req_fun_i[grant*4 +: 4];
                    sel_d   = bus.req_sel_i[grant];
                    a_d     = bus.req_a_i[grant*DATA_W +: DATA_W];
                    b_d     = bus.req_b_i[grant*DATA_W +: DATA_W];
                    imm_d   = bus.req_imm_i[grant*DATA_W +: DATA_W];
`ifdef ALU_ARB_FUNCHK_EN
                    bad_d   = bus.req_fun_i[grant*4 +: 4] > 4'b0100;
`endif
                end
            end
            EXEC: begin
                state_d = RESP;
`ifdef ALU_ARB_FUNCHK_EN
                data_d  = bad_q ? '0 : bus.alu_out_i;
                err_d   = bad_q;
`else
                data_d  = bus.alu_out_i;
                err_d   = 1'b0;
`endif
            end
            RESP: begin
                if (bus.rsp_ready_i[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            owner_q <= '0;
            fun_q   <= '0;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            fun_q   <= fun_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_ARB_FUNCHK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) bad_q <= 1'b0;
        else         bad_q <= bad_d;
    end
`endif

    assign bus.req_ready_o   = accept ? (ONE << grant) : '0;
    assign bus.rsp_valid_o   = (state_q == RESP) ? (ONE << owner_q) : '0;
    assign bus.rsp_data_o    = data_q;
    assign bus.rsp_err_o     = err_q;
    assign bus.alu_sel_o     = sel_q;
    assign bus.alu_fun_o     = fun_q;
    assign bus.alu_reg_a_o   = a_q;
    assign bus.alu_reg_b_o   = b_q;
    assign bus.alu_imm_ext_o = imm_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level reference model.
// Build with +define+ALU_ARB_FUNCHK_EN to cover the illegal-function check.
module tb_alu_arbiter;
    localparam int N = 4;
    localparam int W = 32;
`ifdef ALU_ARB_FUNCHK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   last;
    int   gcnt [N];

    logic [3:0]   fun_a [N];
    logic         sel_a [N];
    logic [W-1:0] a_a   [N];
    logic [W-1:0] b_a   [N];
    logic [W-1:0] imm_a [N];

    alu_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input logic [3:0] f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (f)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    // Stand-in for the shared ALU instance.
    always_comb bus.alu_out_i = alu_f(bus.alu_fun_o, bus.alu_reg_a_o,
        bus.alu_sel_o ? bus.alu_imm_ext_o : bus.alu_reg_b_o);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] r;
        r    = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    // Next winner: first valid requester after the previous winner, wrapping.
    function automatic int pick(input logic [N-1:0] vm);
        for (int j = 1; j <= N; j++) begin
            if (vm[(last + j) % N]) return (last + j) % N;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] v);
        bus.req_valid_i = v;
        for (int k = 0; k < N; k++) begin
            bus.req_fun_i[k*4 +: 4] = fun_a[k];
            bus.req_sel_i[k]        = sel_a[k];
            bus.req_a_i[k*W +: W]   = a_a[k];
            bus.req_b_i[k*W +: W]   = b_a[k];
            bus.req_imm_i[k*W +: W] = imm_a[k];
        end
    endtask

    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            fun_a[k] = 4'($urandom);
            sel_a[k] = 1'($urandom);
            a_a[k]   = $urandom;
            b_a[k]   = $urandom;
            imm_a[k] = $urandom;
        end
    endtask

    // Called just after a rising edge with the DUT in IDLE; returns in IDLE.
    task automatic do_op(input logic [N-1:0] vm, input logic [N-1:0] late,
                         input int stall, input bit scr, output int wo,
                         output logic [W-1:0] dout, output logic eo);
        int           w;
        logic [3:0]   ef;
        logic         es;
        logic [W-1:0] ea, eb, ei, ex;
        logic         ee;
        drive(vm);
        w    = pick(vm);
        wo   = w;
        dout = '0;
        eo   = 1'b0;
        @(negedge clk);
        if (w < 0) begin
            chk("idle_ready", bus.req_ready_o, 0);
            chk("idle_rsp", bus.rsp_valid_o, 0);
            @(posedge clk); #1;
            return;
        end
        chk("ready", bus.req_ready_o, oh(w));
        ef = fun_a[w];
        es = sel_a[w];
        ea = a_a[w];
        eb = b_a[w];
        ei = imm_a[w];
        ex = alu_f(ef, ea, es ? ei : eb);
        ee = 1'b0;
        if (FCHK && ef > 4'd4) begin
            ex = '0;
            ee = 1'b1;
        end
        @(posedge clk); #1;
        last = w;
        gcnt[w]++;
        if (scr) scramble();
        drive(late);
        @(negedge clk);
        chk("exec_fun", bus.alu_fun_o, ef);
        chk("exec_sel", bus.alu_sel_o, es);
        chk("exec_a", bus.alu_reg_a_o, ea);
        chk("exec_b", bus.alu_reg_b_o, eb);
        chk("exec_imm", bus.alu_imm_ext_o, ei);
        chk("exec_ready", bus.req_ready_o, 0);
        chk("exec_rsp", bus.rsp_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid", bus.rsp_valid_o, oh(w));
        chk("rsp_data", bus.rsp_data_o, ex);
        chk("rsp_err", bus.rsp_err_o, ee);
        chk("rsp_ready", bus.req_ready_o, 0);
        dout = bus.rsp_data_o;
        eo   = bus.rsp_err_o;
        for (int s = 0; s < stall; s++) begin
            bus.rsp_ready_i = N'($urandom) & ~oh(w);
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid_o, oh(w));
            chk("stall_data", bus.rsp_data_o, ex);
            chk("stall_ready", bus.req_ready_o, 0);
        end
        bus.rsp_ready_i = oh(w) | N'($urandom);
        @(posedge clk); #1;
        bus.rsp_ready_i = '0;
    endtask

    initial begin : main
        int           wo;
        logic [W-1:0] d;
        logic         e;
        logic [N-1:0] vm;
        n_cmp = 0;
        n_bad = 0;
        last  = N - 1;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            gcnt[k]  = 0;
            fun_a[k] = '0;
            sel_a[k] = 1'b0;
            a_a[k]   = '0;
            b_a[k]   = '0;
            imm_a[k] = '0;
        end
        drive('0);
        bus.rsp_ready_i = '0;

        #12;
        bus.req_valid_i = '1;
        #1;
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_rsp", bus.rsp_valid_o, 0);
        chk("rst_data", bus.rsp_data_o, 0);
        chk("rst_err", bus.rsp_err_o, 0);
        chk("rst_fun", bus.alu_fun_o, 0);
        chk("rst_sel", bus.alu_sel_o, 0);
        chk("rst_a", bus.alu_reg_a_o, 0);
        chk("rst_b", bus.alu_reg_b_o, 0);
        chk("rst_imm", bus.alu_imm_ext_o, 0);
        bus.req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fun_a[0] = 4'd0; a_a[0] = 5; b_a[0] = 7; sel_a[0] = 0;
        do_op(4'b0001, '0, 0, 0, wo, d, e);
        chk("single_gnt", wo, 0);
        chk("single_data", d, 12);

        fun_a[1] = 4'd1; a_a[1] = 10; imm_a[1] = 3; sel_a[1] = 1;
        b_a[1] = 99;
        do_op(4'b0010, '0, 0, 0, wo, d, e);
        chk("imm_gnt", wo, 1);
        chk("imm_data", d, 7);

        fun_a[0] = 4'd2; a_a[0] = 'hF0; b_a[0] = 'h3C; sel_a[0] = 0;
        fun_a[1] = 4'd4; a_a[1] = 'hF0; b_a[1] = 'h0F; sel_a[1] = 0;
        for (int i = 0; i < 4; i++) begin
            do_op(4'b0011, 4'b0011, 0, 0, wo, d, e);
            chk("pair_gnt", wo, i % 2);
            chk("pair_data", d, (i % 2) ? 'hFF : 'h30);
        end

        fun_a[0] = 4'd0; a_a[0] = 1; b_a[0] = 2;
        do_op(4'b0001, 4'b0010, 5, 0, wo, d, e);
        chk("bp_data", d, 3);
        do_op(4'b0010, '0, 0, 0, wo, d, e);
        chk("bp_next", wo, 1);

        fun_a[0] = 4'd3; a_a[0] = 'hA5A5_0000; b_a[0] = 'h5A5A;
        drive(4'b0001);
        @(negedge clk);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp", bus.rsp_valid_o, 0);
        chk("arst_ready", bus.req_ready_o, 0);
        chk("arst_fun", bus.alu_fun_o, 0);
        chk("arst_a", bus.alu_reg_a_o, 0);
        chk("arst_data", bus.rsp_data_o, 0);
        drive('0);
        last = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_quiet", bus.rsp_valid_o, 0);
        end
        @(posedge clk); #1;
        fun_a[1] = 4'd0;
        do_op(4'b0011, '0, 0, 0, wo, d, e);
        chk("arst_prio", wo, 0);

        fun_a[2] = 4'hF; a_a[2] = 1; b_a[2] = 1; sel_a[2] = 0;
        do_op(4'b0100, '0, 0, 0, wo, d, e);
        chk("fchk_err", e, FCHK);
        if (FCHK) chk("fchk_data", d, 0);

        for (int k = 0; k < N; k++) gcnt[k] = 0;
        for (int i = 0; i < 3 * N; i++) begin
            do_op('1, '1, 0, 1, wo, d, e);
        end
        for (int k = 0; k < N; k++) chk("fair_cnt", gcnt[k], 3);

        for (int i = 0; i < 150; i++) begin
            scramble();
            vm = N'($urandom);
            if ($urandom_range(0, 7) == 0) vm = '0;
            do_op(vm, N'($urandom), $urandom_range(0, 3), 1, wo, d, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
